sm_dm_arbiter: RTL and testbench



---
 rtl/sm_dm_arbiter_pkg.sv | 28 ++
 rtl/sm_dm_arbiter_rr_arb2.sv | 25 ++
 rtl/sm_dm_arbiter.sv | 148 ++++++++++++++
 tb/tb_sm_dm_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_dm_arbiter_pkg.sv
// Shared constants for the two-master data-memory arbiter.
package sm_dm_arbiter_pkg;

    // FSM state encodings (2-bit, legacy-compatible values)
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_BUSY0 = 2'd1;
    localparam logic [1:0] ARB_BUSY1 = 2'd2;

    // One-hot grant constants {m1,m0}
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Busy state that holds a transaction for the given master (0 = m0, 1 = m1)
    function automatic logic [1:0] busyStateFor(input logic master);
        return master ? ARB_BUSY1 : ARB_BUSY0;
    endfunction

    // Grant vector presented while a busy state is held
    function automatic logic [1:0] gntForState(input logic [1:0] st);
        logic [1:0] g;
        g = GNT_NONE;
        if (st == ARB_BUSY0) g = GNT_M0;
        if (st == ARB_BUSY1) g = GNT_M1;
        return g;
    endfunction

endpackage

// File: rtl/sm_dm_arbiter_rr_arb2.sv
// Combinational two-way winner select, round-robin or fixed priority.
module sm_dm_arbiter_rr_arb2
    import sm_dm_arbiter_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] req,
    input  logic       lastGnt, // 1 = m1 was granted last
    output logic [1:0] win
);

    // Tie goes to the master not granted last (RR) or always to m0 (fixed)
    always_comb begin
        win = GNT_NONE;
        if (req[0] && req[1]) begin
            if (RR) win = lastGnt ? GNT_M0 : GNT_M1;
            else    win = GNT_M0;
        end else if (req[0]) begin
            win = GNT_M0;
        end else if (req[1]) begin
            win = GNT_M1;
        end
    end

endmodule

// File: rtl/sm_dm_arbiter.sv
// Shares one data-memory slave port between two masters. Grants are decided in
// the request cycle; multi-cycle transactions run from a latched request copy.
module sm_dm_arbiter
    import sm_dm_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter bit          RR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [AW-1:0] m0_addr,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_valid,
    output logic          m0_ready,
    output logic [DW-1:0] m0_rdata,

    input  logic [AW-1:0] m1_addr,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_valid,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] s_addr,
    output logic          s_we,
    output logic [DW-1:0] s_wdata,
    output logic          s_valid,
    input  logic          s_ready,
    input  logic [DW-1:0] s_rdata,

    output logic [1:0]    gnt
);

    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic          lastGnt;
    logic          lastGntNext;
    logic          capture;
    logic [1:0]    win;

    logic [AW-1:0] latAddr;
    logic          latWe;
    logic [DW-1:0] latWData;

    logic [AW-1:0] winAddr;
    logic          winWe;
    logic [DW-1:0] winWData;

    sm_dm_arbiter_rr_arb2 #(
        .RR (RR)
    ) uArb (
        .req     ({m1_valid, m0_valid}),
        .lastGnt (lastGnt),
        .win     (win)
    );

    // Read data is broadcast; it only means something alongside ready
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    // Select the IDLE-cycle winner's request signals
    always_comb begin
        if (win[1]) begin
            winAddr  = m1_addr;
            winWe    = m1_we;
            winWData = m1_wdata;
        end else begin
            winAddr  = m0_addr;
            winWe    = m0_we;
            winWData = m0_wdata;
        end
    end

    // Next-state, slave muxing and ready generation
    always_comb begin
        stateNext   = state;
        lastGntNext = lastGnt;
        capture     = 1'b0;
        s_valid     = 1'b0;
        s_we        = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        gnt         = GNT_NONE;
        m0_ready    = 1'b1;
        m1_ready    = 1'b1;

        if (rst_n) begin
            case (state)
                ARB_IDLE: begin
                    if (win != GNT_NONE) begin
                        gnt     = win;
                        s_valid = 1'b1;
                        s_addr  = winAddr;
                        s_we    = winWe;
                        s_wdata = winWData;
                        if (s_ready) begin
                            lastGntNext = win[1];
                        end else begin
                            capture   = 1'b1;
                            stateNext = busyStateFor(win[1]);
                        end
                    end
                end
                ARB_BUSY0, ARB_BUSY1: begin
                    gnt     = gntForState(state);
                    s_valid = 1'b1;
                    s_addr  = latAddr;
                    s_we    = latWe;
                    s_wdata = latWData;
                    if (s_ready) begin
                        stateNext   = ARB_IDLE;
                        lastGntNext = (state == ARB_BUSY1);
                    end
                end
                default: begin
                    stateNext = ARB_IDLE;
                end
            endcase

            // An idle master is never stalled; a requester completes only when granted
            m0_ready = ~m0_valid | (gnt[0] & s_ready);
            m1_ready = ~m1_valid | (gnt[1] & s_ready);
        end
    end

    // State, last-grant and request-latch registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            lastGnt  <= 1'b1;
            latAddr  <= '0;
            latWe    <= 1'b0;
            latWData <= '0;
        end else begin
            state   <= stateNext;
            lastGnt <= lastGntNext;
            if (capture) begin
                latAddr  <= winAddr;
                latWe    <= winWe;
                latWData <= winWData;
            end
        end
    end

endmodule

// File: tb/tb_sm_dm_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, with a
// transaction-level reference model for a round-robin and a fixed-priority DUT.
module tb_sm_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic        m0_we, m0_valid, m1_we, m1_valid, s_ready;

    // index 0 = round-robin instance, 1 = fixed-priority instance
    logic        m0Ready [2];
    logic        m1Ready [2];
    logic [31:0] m0RData [2];
    logic [31:0] m1RData [2];
    logic [31:0] sAddr   [2];
    logic        sWe     [2];
    logic [31:0] sWData  [2];
    logic        sValid  [2];
    logic [1:0]  gntO    [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm_dm_arbiter #(.AW(32), .DW(32), .RR(1'b1)) dutRr (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
        .m0_ready(m0Ready[0]), .m0_rdata(m0RData[0]),
        .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
        .m1_ready(m1Ready[0]), .m1_rdata(m1RData[0]),
        .s_addr(sAddr[0]), .s_we(sWe[0]), .s_wdata(sWData[0]), .s_valid(sValid[0]),
        .s_ready(s_ready), .s_rdata(s_rdata), .gnt(gntO[0])
    );

    sm_dm_arbiter #(.AW(32), .DW(32), .RR(1'b0)) dutFp (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
        .m0_ready(m0Ready[1]), .m0_rdata(m0RData[1]),
        .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
        .m1_ready(m1Ready[1]), .m1_rdata(m1RData[1]),
        .s_addr(sAddr[1]), .s_we(sWe[1]), .s_wdata(sWData[1]), .s_valid(sValid[1]),
        .s_ready(s_ready), .s_rdata(s_rdata), .gnt(gntO[1])
    );

    // Reference model: who owns an outstanding transaction (-1 = nobody),
    // the held request, and who won last.
    int          owner [2];
    int          lastW [2];
    logic [31:0] hAddr [2];
    logic [31:0] hData [2];
    logic        hWe   [2];

    logic [31:0] eAddr, eWData;
    logic        eValid, eWe, eR0, eR1;
    logic [1:0]  eGnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int k);
        if (m0_valid && m1_valid) return (k == 0 && lastW[k] == 0) ? 1 : 0;
        if (m0_valid) return 0;
        if (m1_valid) return 1;
        return -1;
    endfunction

    task automatic modelOut(input int k);
        int w;
        eValid = 0; eWe = 0; eAddr = 0; eWData = 0; eGnt = 0; eR0 = 1; eR1 = 1;
        if (!rst_n) return;
        if (owner[k] < 0) begin
            w = pick(k);
            if (w >= 0) begin
                eValid = 1;
                eAddr  = (w == 0) ? m0_addr  : m1_addr;
                eWData = (w == 0) ? m0_wdata : m1_wdata;
                eWe    = (w == 0) ? m0_we    : m1_we;
            end
        end else begin
            w = owner[k];
            eValid = 1; eAddr = hAddr[k]; eWData = hData[k]; eWe = hWe[k];
        end
        if (w == 0) eGnt = 2'b01;
        if (w == 1) eGnt = 2'b10;
        eR0 = !m0_valid || (w == 0 && s_ready);
        eR1 = !m1_valid || (w == 1 && s_ready);
    endtask

    task automatic modelStep(input int k);
        int w;
        if (!rst_n) begin
            owner[k] = -1; lastW[k] = 1; hAddr[k] = 0; hData[k] = 0; hWe[k] = 0;
        end else if (owner[k] < 0) begin
            w = pick(k);
            if (w >= 0) begin
                if (s_ready) lastW[k] = w;
                else begin
                    owner[k] = w;
                    hAddr[k] = (w == 0) ? m0_addr  : m1_addr;
                    hData[k] = (w == 0) ? m0_wdata : m1_wdata;
                    hWe[k]   = (w == 0) ? m0_we    : m1_we;
                end
            end
        end else if (s_ready) begin
            lastW[k] = owner[k];
            owner[k] = -1;
        end
    endtask

    // Wait for outputs to settle mid-cycle, then compare both DUTs with the model
    task automatic settle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            modelOut(k);
            chk($sformatf("s_valid[%0d]", k), 64'(sValid[k]), 64'(eValid));
            chk($sformatf("s_we[%0d]", k), 64'(sWe[k]), 64'(eWe));
            chk($sformatf("s_addr[%0d]", k), 64'(sAddr[k]), 64'(eAddr));
            chk($sformatf("s_wdata[%0d]", k), 64'(sWData[k]), 64'(eWData));
            chk($sformatf("gnt[%0d]", k), 64'(gntO[k]), 64'(eGnt));
            chk($sformatf("m0_ready[%0d]", k), 64'(m0Ready[k]), 64'(eR0));
            chk($sformatf("m1_ready[%0d]", k), 64'(m1Ready[k]), 64'(eR1));
            chk($sformatf("m0_rdata[%0d]", k), 64'(m0RData[k]), 64'(s_rdata));
            chk($sformatf("m1_rdata[%0d]", k), 64'(m1RData[k]), 64'(s_rdata));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; lastW[k] = 1; hAddr[k] = 0; hData[k] = 0; hWe[k] = 0;
        end
        rst_n = 0; s_ready = 0; s_rdata = 0;
        m0_addr = 0; m0_we = 0; m0_wdata = 0; m0_valid = 0;
        m1_addr = 0; m1_we = 0; m1_wdata = 0; m1_valid = 0;
        #1;

        // Reset state, even with requests pending
        m0_valid = 1; m1_valid = 1; m0_we = 1; m0_addr = 32'h44;
        settle();
        chk("rst_s_valid", 64'(sValid[0]), 64'd0);
        chk("rst_s_we", 64'(sWe[0]), 64'd0);
        chk("rst_s_addr", 64'(sAddr[0]), 64'd0);
        chk("rst_gnt", 64'(gntO[0]), 64'd0);
        chk("rst_m0_ready", 64'(m0Ready[0]), 64'd1);
        chk("rst_m1_ready", 64'(m1Ready[0]), 64'd1);
        adv();
        m0_valid = 0; m1_valid = 0; m0_we = 0;
        settle(); adv();

        // Single-cycle read by m0
        rst_n = 1; m0_valid = 1; m0_addr = 32'h10; s_ready = 1; s_rdata = 32'hCAFE;
        settle();
        chk("rd1_m0_ready", 64'(m0Ready[0]), 64'd1);
        chk("rd1_m0_rdata", 64'(m0RData[0]), 64'hCAFE);
        chk("rd1_gnt", 64'(gntO[0]), 64'b01);
        chk("rd1_s_addr", 64'(sAddr[0]), 64'h10);
        adv();
        m0_valid = 0;

        // Tie after reset with a 3-cycle slave: m0 then m1
        rst_n = 0; s_ready = 0; settle(); adv(); rst_n = 1;
        m0_valid = 1; m1_valid = 1; m0_addr = 32'hA0; m1_addr = 32'hB0;
        for (int c = 0; c < 3; c++) begin
            s_ready = (c == 2);
            settle();
            chk($sformatf("tie_gnt_m0_c%0d", c), 64'(gntO[0]), 64'b01);
            chk($sformatf("tie_m1_wait_c%0d", c), 64'(m1Ready[0]), 64'd0);
            chk($sformatf("tie_m0_ready_c%0d", c), 64'(m0Ready[0]), 64'(c == 2));
            adv();
        end
        m0_valid = 0;
        for (int c = 0; c < 3; c++) begin
            s_ready = (c == 2);
            settle();
            chk($sformatf("tie_gnt_m1_c%0d", c), 64'(gntO[0]), 64'b10);
            chk($sformatf("tie_s_addr_m1_c%0d", c), 64'(sAddr[0]), 64'hB0);
            chk($sformatf("tie_m1_ready_c%0d", c), 64'(m1Ready[0]), 64'(c == 2));
            adv();
        end
        m1_valid = 0;

        // Continuous contention: fixed priority starves m1, round-robin alternates
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("fp_gnt_c%0d", c), 64'(gntO[1]), 64'b01);
            chk($sformatf("fp_m1_ready_c%0d", c), 64'(m1Ready[1]), 64'd0);
            chk($sformatf("rr_gnt_c%0d", c), 64'(gntO[0]), (c % 2 == 0) ? 64'b01 : 64'b10);
            adv();
        end
        m0_valid = 0; m1_valid = 0;

        // m1 write held stable while m1 changes its address
        m1_valid = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55; s_ready = 0;
        settle();
        chk("wr_s_addr_c0", 64'(sAddr[0]), 64'h20);
        chk("wr_s_we_c0", 64'(sWe[0]), 64'd1);
        chk("wr_s_wdata_c0", 64'(sWData[0]), 64'h55);
        adv();
        m1_addr = 32'h30; m1_wdata = 32'h99; m1_we = 0; s_ready = 1;
        settle();
        chk("wr_s_addr_c1", 64'(sAddr[0]), 64'h20);
        chk("wr_s_we_c1", 64'(sWe[0]), 64'd1);
        chk("wr_s_wdata_c1", 64'(sWData[0]), 64'h55);
        chk("wr_m1_ready_c1", 64'(m1Ready[0]), 64'd1);
        adv();
        m1_valid = 0;

        // No requests
        for (int c = 0; c < 3; c++) begin
            s_ready = c[0];
            settle();
            chk($sformatf("idle_s_valid_c%0d", c), 64'(sValid[0]), 64'd0);
            chk($sformatf("idle_s_we_c%0d", c), 64'(sWe[0]), 64'd0);
            chk($sformatf("idle_ready_c%0d", c), 64'({m1Ready[0], m0Ready[0]}), 64'b11);
            adv();
        end

        // Reset while m1 holds a transaction
        m1_valid = 1; m1_addr = 32'h77; s_ready = 0;
        settle(); adv();
        settle();
        chk("busy1_gnt", 64'(gntO[0]), 64'b10);
        adv();
        rst_n = 0;
        settle();
        chk("midrst_s_valid", 64'(sValid[0]), 64'd0);
        adv();
        rst_n = 1; m1_valid = 0;
        settle();
        chk("postrst_s_valid", 64'(sValid[0]), 64'd0);
        chk("postrst_gnt", 64'(gntO[0]), 64'd0);
        adv();
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        settle();
        chk("postrst_tie_gnt", 64'(gntO[0]), 64'b01);
        adv();

        // Random traffic, including mid-transaction input changes and rare resets
        for (int c = 0; c < 600; c++) begin
            rst_n    = ($urandom_range(0, 59) != 0);
            m0_valid = $urandom_range(0, 2) != 0;
            m1_valid = $urandom_range(0, 2) != 0;
            m0_we    = $urandom_range(0, 1) == 1;
            m1_we    = $urandom_range(0, 1) == 1;
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            s_ready  = $urandom_range(0, 2) == 0;
            s_rdata  = $urandom;
            settle();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
